// File: rtl/m_led_sequencer.sv
// m_led_sequencer
//   Steps a 4-bit LED pattern once every P_DIV un-held clock cycles while
//   running. Four patterns: blink-all (invert), walk-left (rotate left),
//   walk-right (rotate right) and binary count. A run lasts w_steps ticks,
//   or forever when w_steps is zero, and ends with a one-cycle r_done pulse.
//
// Ports
//   w_clk    in   system clock, rising edge
//   w_rst    in   asynchronous active-high reset
//   w_start  in   start request, accepted in IDLE or DONE
//   w_stop   in   abort request, beats start, ticks and completion
//   w_hold   in   freezes prescaler, pattern and step count while running
//   w_mode   in   [1:0] pattern select (0 blink, 1 walk-left, 2 walk-right, 3 count)
//   w_steps  in   [7:0] ticks per run, 0 = run until stopped
//   r_led    out  [3:0] registered LED pattern
//   r_busy   out  registered, high exactly in RUN cycles
//   r_done   out  registered one-cycle completion pulse (the DONE cycle)
module m_led_sequencer #(
   parameter int unsigned P_DIV = 1000000
) (
   input  logic       w_clk,
   input  logic       w_rst,
   input  logic       w_start,
   input  logic       w_stop,
   input  logic       w_hold,
   input  logic [1:0] w_mode,
   input  logic [7:0] w_steps,
   output logic [3:0] r_led,
   output logic       r_busy,
   output logic       r_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] presc_q, presc_d;
   logic [7:0]  cnt_q,   cnt_d;
   logic [1:0]  mode_q,  mode_d;
   logic [3:0]  led_q,   led_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;

   function automatic logic [3:0] init_pat(input logic [1:0] m);
      logic [3:0] p;
      unique case (m)
         2'd1:    p = 4'b0001;
         2'd2:    p = 4'b1000;
         default: p = 4'b0000;
      endcase
      return p;
   endfunction

   function automatic logic [3:0] next_pat(input logic [1:0] m, input logic [3:0] p);
      logic [3:0] n;
      unique case (m)
         2'd0:    n = ~p;
         2'd1:    n = {p[2:0], p[3]};
         2'd2:    n = {p[0], p[3:1]};
         default: n = p + 4'd1;
      endcase
      return n;
   endfunction

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      led_d   = led_q;

      unique case (state_q)
         S_IDLE: begin
            if (w_stop) begin
               led_d = '0;
            end else if (w_start) begin
               state_d = S_RUN;
               mode_d  = w_mode;
               cnt_d   = w_steps;
               presc_d = '0;
               led_d   = init_pat(w_mode);
            end
         end
         S_RUN: begin
            if (w_stop) begin
               state_d = S_IDLE;
               led_d   = '0;
            end else if (!w_hold) begin
               if (presc_q == P_DIV - 1) begin
                  presc_d = '0;
                  led_d   = next_pat(mode_q, led_q);
                  // A count of zero while running can only mean an endless
                  // run, because a finite run leaves RUN as the count hits 0.
                  if (cnt_q != 8'd0) begin
                     cnt_d = cnt_q - 8'd1;
                     if (cnt_q == 8'd1) begin
                        state_d = S_DONE;
                     end
                  end
               end else begin
                  presc_d = presc_q + 32'd1;
               end
            end
         end
         S_DONE: begin
            if (w_stop) begin
               state_d = S_IDLE;
               led_d   = '0;
            end else if (w_start) begin
               state_d = S_RUN;
               mode_d  = w_mode;
               cnt_d   = w_steps;
               presc_d = '0;
               led_d   = init_pat(w_mode);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            led_d   = '0;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // with the state the FSM is actually in.
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign r_led  = led_q;
   assign r_busy = busy_q;
   assign r_done = done_q;

endmodule

// File: tb/tb_m_led_sequencer.sv
// tb_m_led_sequencer
//   Bench for m_led_sequencer: one instance with P_DIV=4 and one with P_DIV=2.
//   Scenario tasks push expected (cycle, led, busy, done) entries into a
//   scoreboard queue while driving stimulus; a negedge monitor pops and
//   compares them as the DUT cycles arrive.
module tb_m_led_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stop, hold;
   logic [1:0] mode;
   logic [7:0] steps;
   logic [3:0] led1;
   logic       busy1, done1;

   logic       start2, stop2, hold2;
   logic [1:0] mode2;
   logic [7:0] steps2;
   logic [3:0] led2;
   logic       busy2, done2;

   int unsigned cyc   = 0;
   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      int unsigned cyc;
      bit          sel;
      logic [3:0]  led;
      logic        busy;
      logic        done;
      logic [95:0] nm;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   logic [5:0] mon_act;

   m_led_sequencer #(.P_DIV(4)) u_dut4 (
      .w_clk(clk), .w_rst(rst), .w_start(start), .w_stop(stop), .w_hold(hold),
      .w_mode(mode), .w_steps(steps), .r_led(led1), .r_busy(busy1), .r_done(done1)
   );

   m_led_sequencer #(.P_DIV(2)) u_dut2 (
      .w_clk(clk), .w_rst(rst), .w_start(start2), .w_stop(stop2), .w_hold(hold2),
      .w_mode(mode2), .w_steps(steps2), .r_led(led2), .r_busy(busy2), .r_done(done2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Scoreboard monitor: outputs are sampled on the falling edge.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e   = q.pop_front();
         mon_act = mon_e.sel ? {led2, busy2, done2} : {led1, busy1, done1};
         total++;
         if (mon_e.cyc != cyc || mon_act !== {mon_e.led, mon_e.busy, mon_e.done}) begin
            bad++;
            $display("FAIL %0s@%0d: got led=%b busy=%b done=%b, want led=%b busy=%b done=%b (at cycle %0d)",
                     mon_e.nm, cyc, mon_act[5:2], mon_act[1], mon_act[0],
                     mon_e.led, mon_e.busy, mon_e.done, mon_e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int unsigned c, input bit s, input logic [3:0] l,
                       input logic b, input logic d, input logic [95:0] n);
      exp_t e;
      e.cyc = c; e.sel = s; e.led = l; e.busy = b; e.done = d; e.nm = n;
      q.push_back(e);
   endtask

   task automatic drain();
      int unsigned g = 0;
      while (q.size() > 0 && g < 300) begin
         tick();
         g++;
      end
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations unconsumed, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; mode = 2'd1; steps = 8'd3;
      tick();
      tick();
      total++;
      if ({led1, busy1, done1} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL reset_hold: got led=%b busy=%b done=%b, want 0000 0 0", led1, busy1, done1);
      end
      total++;
      if ({led2, busy2, done2} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL reset_hold2: got led=%b busy=%b done=%b, want 0000 0 0", led2, busy2, done2);
      end
      rst = 1'b0;
      tick();
      total++;
      if ({led1, busy1, done1} !== 6'b0001_1_0) begin
         bad++;
         $display("FAIL reset_first_accept: got led=%b busy=%b done=%b, want 0001 1 0", led1, busy1, done1);
      end
      start = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      total++;
      if ({led1, busy1, done1} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL reset_stop: got led=%b busy=%b done=%b, want 0000 0 0", led1, busy1, done1);
      end
      tick();
   endtask

   task automatic test_walk_left();
      int unsigned c = cyc;
      mode = 2'd1; steps = 8'd3; start = 1'b1;
      push(c + 1,  0, 4'b0001, 1, 0, "wl_enter");
      push(c + 4,  0, 4'b0001, 1, 0, "wl_pre1");
      push(c + 5,  0, 4'b0010, 1, 0, "wl_tick1");
      push(c + 9,  0, 4'b0100, 1, 0, "wl_tick2");
      push(c + 12, 0, 4'b0100, 1, 0, "wl_pre3");
      push(c + 13, 0, 4'b1000, 0, 1, "wl_done");
      push(c + 14, 0, 4'b1000, 0, 0, "wl_idle");
      push(c + 16, 0, 4'b1000, 0, 0, "wl_held");
      tick();
      start = 1'b0;
      drain();
   endtask

   task automatic test_count_free();
      int unsigned c = cyc;
      int unsigned s;
      logic [4:0] k5;
      mode = 2'd3; steps = 8'd0; start = 1'b1;
      push(c + 1, 0, 4'b0000, 1, 0, "cnt_enter");
      for (int unsigned k = 1; k <= 20; k++) begin
         k5 = k[4:0];
         push(c + 1 + 4 * k, 0, k5[3:0], 1, 0, "cnt_tick");
      end
      tick();
      start = 1'b0;
      drain();
      s = cyc;
      stop = 1'b1;
      push(s + 1, 0, 4'b0000, 0, 0, "cnt_stop");
      push(s + 2, 0, 4'b0000, 0, 0, "cnt_idle");
      tick();
      stop = 1'b0;
      drain();
   endtask

   task automatic test_hold();
      int unsigned c = cyc;
      mode = 2'd0; steps = 8'd2; start = 1'b1;
      push(c + 1,  0, 4'b0000, 1, 0, "hold_enter");
      push(c + 5,  0, 4'b0000, 1, 0, "hold_notick");
      push(c + 10, 0, 4'b0000, 1, 0, "hold_frozen");
      push(c + 14, 0, 4'b0000, 1, 0, "hold_pre1");
      push(c + 15, 0, 4'b1111, 1, 0, "hold_tick1");
      push(c + 18, 0, 4'b1111, 1, 0, "hold_pre2");
      push(c + 19, 0, 4'b0000, 0, 1, "hold_done");
      push(c + 20, 0, 4'b0000, 0, 0, "hold_idle");
      tick();
      start = 1'b0;
      tick();
      hold = 1'b1;
      repeat (10) tick();
      hold = 1'b0;
      drain();
   endtask

   task automatic test_stop_vs_start();
      int unsigned c = cyc;
      mode = 2'd1; steps = 8'd0; start = 1'b1;
      push(c + 1, 0, 4'b0001, 1, 0, "ss_enter");
      push(c + 4, 0, 4'b0001, 1, 0, "ss_pre");
      push(c + 5, 0, 4'b0000, 0, 0, "ss_stop");
      push(c + 6, 0, 4'b0000, 0, 0, "ss_norestart");
      push(c + 8, 0, 4'b0000, 0, 0, "ss_idle");
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      drain();
   endtask

   task automatic test_async_reset();
      int unsigned c = cyc;
      int unsigned r;
      mode = 2'd2; steps = 8'd0; start = 1'b1;
      push(c + 1, 0, 4'b1000, 1, 0, "ar_enter");
      push(c + 5, 0, 4'b0100, 1, 0, "ar_tick1");
      push(c + 6, 0, 4'b0100, 1, 0, "ar_run");
      tick();
      start = 1'b0;
      drain();
      rst = 1'b1;
      #1;
      total++;
      if ({led1, busy1, done1} !== 6'b0000_0_0) begin
         bad++;
         $display("FAIL ar_async: got led=%b busy=%b done=%b, want 0000 0 0", led1, busy1, done1);
      end
      rst = 1'b0;
      #1;
      r = cyc;
      push(r + 1, 0, 4'b0000, 0, 0, "ar_nodone");
      push(r + 3, 0, 4'b0000, 0, 0, "ar_idle");
      drain();
   endtask

   task automatic test_back_to_back();
      int unsigned c = cyc;
      mode = 2'd1; steps = 8'd1; start = 1'b1;
      push(c + 1,  0, 4'b0001, 1, 0, "bb_enter");
      push(c + 5,  0, 4'b0010, 0, 1, "bb_done1");
      push(c + 6,  0, 4'b0000, 1, 0, "bb_rerun");
      push(c + 10, 0, 4'b0001, 1, 0, "bb_tick1");
      push(c + 14, 0, 4'b0010, 0, 1, "bb_done2");
      push(c + 15, 0, 4'b0010, 0, 0, "bb_idle");
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      mode = 2'd3; steps = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      drain();
   endtask

   task automatic test_pdiv2();
      int unsigned c = cyc;
      mode2 = 2'd3; steps2 = 8'd1; start2 = 1'b1;
      push(c + 1, 1, 4'b0000, 1, 0, "p2_enter");
      push(c + 2, 1, 4'b0000, 1, 0, "p2_wait");
      push(c + 3, 1, 4'b0001, 0, 1, "p2_done");
      push(c + 4, 1, 4'b0001, 0, 0, "p2_idle");
      tick();
      start2 = 1'b0;
      drain();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = '0; steps = '0;
      start2 = 1'b0; stop2 = 1'b0; hold2 = 1'b0; mode2 = '0; steps2 = '0;
      test_reset();
      test_walk_left();
      test_count_free();
      test_hold();
      test_stop_vs_start();
      test_async_reset();
      test_back_to_back();
      test_pdiv2();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/m_led_sequencer.md
M_LED_SEQUENCER -- requirements
Module: m_led_sequencer

Interface
REQ-001 SHALL provide parameter P_DIV, default 1000000, meaning clock cycles per pattern step (legal range 2..2^32-1).
REQ-002 SHALL provide port w_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port w_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port w_start  input  1  start request, sampled each cycle.
REQ-005 SHALL provide port w_stop  input  1  abort request, sampled each cycle.
REQ-006 SHALL provide port w_hold  input  1  freeze prescaler and pattern while high.
REQ-007 SHALL provide port w_mode  input  2  pattern select: 0 blink-all, 1 walk-left, 2 walk-right, 3 binary count.
REQ-008 SHALL provide port w_steps  input  8  step count; 0 means run until stopped.
REQ-009 SHALL provide port r_led  output  4  LED pattern, registered.
REQ-010 SHALL provide port r_busy  output  1  high in RUN, registered.
REQ-011 SHALL provide port r_done  output  1  one-cycle completion pulse, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE on reset.
REQ-013 SHALL accept w_start only in IDLE or DONE; w_start in RUN is ignored.
REQ-014 SHALL, on accept, latch w_mode and w_steps, clear the prescaler to 0, load the initial pattern (mode0 0000, mode1 0001, mode2 1000, mode3 0000), and enter RUN the next cycle.
REQ-015 SHALL, in RUN with w_hold low, increment a 32-bit prescaler each cycle; at value P_DIV-1 it wraps to 0 and generates one step tick.
REQ-016 SHALL, in RUN with w_hold high, keep prescaler, pattern and step counter unchanged.
REQ-017 SHALL update r_led on each tick: mode0 bitwise invert, mode1 rotate left by 1 (bit3 to bit0), mode2 rotate right by 1 (bit0 to bit3), mode3 add 1 modulo 16.
REQ-018 SHALL make the first tick occur exactly P_DIV cycles after the first RUN cycle; subsequent ticks every P_DIV un-held cycles.
REQ-019 SHALL, for latched steps N>0, decrement the remaining count per tick and enter DONE on the tick that brings it to 0, with r_led showing the N-th updated pattern.
REQ-020 SHALL, for latched steps 0, stay in RUN indefinitely; the step counter does not change.
REQ-021 SHALL remain in DONE exactly one cycle with r_done=1, r_led held, then return to IDLE unless w_start is accepted in that cycle (then RUN).
REQ-022 SHALL, on w_stop in RUN or DONE, enter IDLE next cycle and clear r_led to 0000 with r_done=0.
REQ-023 SHALL give w_stop priority over w_start and over a coincident tick or completion.
REQ-024 SHALL hold r_led unchanged in IDLE after normal completion until the next accept or stop.
REQ-025 SHALL drive r_busy=1 exactly in RUN cycles, registered from the state.
REQ-026 SHALL treat w_hold as ignored outside RUN.

Reset
REQ-027 SHALL, on w_rst high, immediately force IDLE, r_led=0000, r_busy=0, r_done=0, prescaler=0, step counter=0.
REQ-028 SHALL abandon any sequence in progress when reset asserts mid-RUN, with no r_done pulse.
REQ-029 SHALL ignore w_start while w_rst is high; the first accept may occur on the first edge after release.

Verification (P_DIV=4 unless noted)
REQ-030 SHALL cover: start, mode1, steps 3 -> r_busy rises next cycle; r_led 0001, then 0010, 0100, 1000 at 4-cycle spacing; r_done one cycle; then IDLE with r_led 1000.
REQ-031 SHALL cover: start, mode3, steps 0, run 20 ticks -> r_led counts 0001..1111,0000,...,0100 and never completes; then w_stop -> IDLE next cycle, r_led 0000.
REQ-032 SHALL cover: mode0 run with w_hold high 10 cycles mid-interval -> tick delayed by exactly 10 cycles, no pattern change during hold.
REQ-033 SHALL cover: w_start and w_stop both high in RUN on a tick cycle -> IDLE, r_led 0000, no r_done, restart not accepted.
REQ-034 SHALL cover: asynchronous w_rst pulse between clock edges mid-RUN mode2 -> outputs 0 before the next edge; w_start in DONE cycle -> immediate RUN with new mode.
REQ-035 SHALL cover: P_DIV=2, steps 1 -> single tick 2 cycles after RUN entry, r_done pulse following that cycle.
